w0rm_core_fetch: RTL and testbench
==================================

# w0rm_core_fetch

Instruction fetch unit for the W0RM core: the initiator on the instruction port of `W0RM_CoreMemory`. It generates sequential 16-bit instruction addresses, issues read requests, and buffers in-order responses in a small FIFO. It hands instructions with their PCs to decode over a valid/ready handshake and redirects on branches, discarding stale in-flight responses. It sits between `W0RM_CoreMemory` and the decode stage.

## Interface
- `INST_WIDTH`, 16: instruction width; the PC advances by `INST_WIDTH/8` = 2 bytes per instruction.
- `ADDR_WIDTH`, 32: address width.
- `RESET_PC`, 32'h20000000: first fetch address after reset.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, at least 2.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_inst_addr`  out  ADDR_WIDTH  request address; drives memory `inst_addr`.
- `mem_inst_read`  out  1  read strobe; drives memory `inst_read`.
- `mem_inst_valid`  out  1  request valid; drives memory `inst_valid_in`.
- `mem_inst_data`  in  INST_WIDTH  response data; from memory `inst_data_out`.
- `mem_inst_resp`  in  1  response valid; from memory `inst_valid_out`. Responses return in request order with any latency of 1 cycle or more.
- `branch_valid`  in  1  redirect strobe, one cycle.
- `branch_addr`  in  ADDR_WIDTH  redirect target; bit 0 is ignored and treated as 0.
- `inst_out`  out  INST_WIDTH  instruction to decode.
- `inst_pc`  out  ADDR_WIDTH  address of `inst_out`.
- `inst_valid`  out  1  `inst_out`/`inst_pc` are valid.
- `inst_ready`  in  1  decode accepts; a pop occurs when `inst_valid && inst_ready`.

## Operation
State:
- `fetch_pc`: next address to request.
- `out_pc`: PC of the FIFO head.
- FIFO: `count`, head and tail pointers.
- `inflight`: requests issued and not yet answered.
- `discard`: in-flight requests whose responses must be dropped.
- Width of `inflight` and `discard`: clog2(FIFO_DEPTH)+1 bits.

Request issue:
- Condition: not in reset, no `branch_valid` this cycle, and `count + (inflight - discard) < FIFO_DEPTH` using current-cycle values.
- On issue: `mem_inst_valid = mem_inst_read = 1`, `mem_inst_addr = fetch_pc`; `fetch_pc += 2` and `inflight += 1`.
- Request outputs are combinational from registered state and credit. At most one request per cycle.

Response:
- On `mem_inst_resp`, `inflight -= 1`.
- If `discard > 0`: `discard -= 1` and the data is dropped.
- Otherwise the data is written at the FIFO tail. Overflow cannot occur by construction; the bench asserts it never does.

Output:
- `inst_valid = (count != 0)`.
- `inst_out` = FIFO head.
- `inst_pc = out_pc`.
- On pop: head advances and `out_pc += 2`.
- Push and pop in the same cycle leave `count` unchanged.

Redirect (`branch_valid` = 1), with priority over everything else in that cycle:
- FIFO is cleared: `count = 0`, pointers reset.
- `fetch_pc = out_pc = branch_addr & ~1`.
- `discard = inflight - (mem_inst_resp ? 1 : 0)`, i.e. every response still outstanding is dropped. A response arriving in the branch cycle is itself dropped.
- No request is issued in the branch cycle. Any pop in that cycle has no effect.
- A second branch while `discard > 0` recomputes `discard` with the same formula.

Reset:
- `fetch_pc = out_pc = RESET_PC`; `count`, `inflight`, `discard`, pointers = 0.
- All outputs are 0 during reset. `inst_pc` reads `RESET_PC` once reset is released.
- Responses arriving during or after reset that belong to pre-reset requests are not tracked. The system resets memory together with fetch.

Arithmetic:
- PC increments are modulo 2^ADDR_WIDTH; 32'hFFFFFFFE + 2 wraps to 0.

## Timing
- First request: the first cycle with `reset` low.
- Request-to-`inst_valid` latency: L + 1 cycles, where L is the memory response latency. The response is registered into the FIFO, with no fall-through.
- Sustained throughput: 1 instruction/cycle when `inst_ready` = 1 and `FIFO_DEPTH > L + 1`.
- After `branch_valid` in cycle N: first request to the target in N+1; `inst_valid` = 0 from N+1 until the first target response has been written.
- Backpressure: with `inst_ready` = 0, issue stops once `count + live inflight = FIFO_DEPTH`, then resumes the cycle after a pop frees an entry.

## Test plan
- Reset release with a 1-cycle-latency memory and `inst_ready` = 1: requests go to 0x20000000, 0x20000002, … one per cycle; `inst_valid` first rises 2 cycles after the first request, with `inst_pc` = 0x20000000 and data matching the memory image.
- `inst_ready` held 0 with a 1-cycle memory: exactly 4 requests issued, `count` = 4, `mem_inst_valid` then stays 0; raising `inst_ready` for one cycle gives exactly one new request, issued the cycle after the pop.
- 3-cycle memory with 3 requests in flight, then `branch_valid` with `branch_addr` = 0x20000101: the 3 stale responses are dropped; the next `inst_pc` is 0x20000100; the first request after the branch is to 0x20000100, in the cycle after the branch.
- Branch in the same cycle as a response and a pop: the response is dropped, `count` = 0 on the next cycle, and `discard` = `inflight` − 1.
- Two branches two cycles apart (to 0x100, then 0x200) with 2-cycle memory latency: only instructions from 0x200 onward ever reach decode.
- `reset` asserted mid-stream: all outputs are 0 on the next cycle; after release, fetch restarts at `RESET_PC` and no stale instruction appears.

Source files
------------

// File: rtl/w0rm_core_fetch.sv
// W0RM instruction fetch: sequential request issue, in-order response FIFO,
// branch redirect with stale-response discard.
module w0rm_core_fetch #(
    parameter int INST_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h2000_0000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_inst_addr,
    output logic                  mem_inst_read,
    output logic                  mem_inst_valid,
    input  logic [INST_WIDTH-1:0] mem_inst_data,
    input  logic                  mem_inst_resp,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_WIDTH / 8);
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         discard;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [INST_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [CW:0] occupancy;
    logic        issue;
    logic        push;
    logic        pop;
    logic        has_data;

    // Credit counts buffered entries plus responses that will still land.
    assign occupancy = {1'b0, count} + {1'b0, inflight - discard};
    assign issue     = !reset && !branch_valid && (occupancy < DEPTH);
    assign push      = mem_inst_resp && (discard == '0);
    assign has_data  = (count != '0);
    assign pop       = has_data && inst_ready;

    assign mem_inst_valid = issue;
    assign mem_inst_read  = issue;
    assign mem_inst_addr  = issue ? fetch_pc : '0;

    assign inst_valid = !reset && has_data;
    assign inst_out   = reset ? '0 : fifo_mem[head];
    assign inst_pc    = reset ? '0 : out_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            out_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (branch_valid) begin
            fetch_pc <= branch_addr & ~ADDR_WIDTH'(1);
            out_pc   <= branch_addr & ~ADDR_WIDTH'(1);
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= inflight - CW'(mem_inst_resp);
            discard  <= inflight - CW'(mem_inst_resp);
        end else begin
            if (issue)
                fetch_pc <= fetch_pc + STEP;
            inflight <= inflight + CW'(issue) - CW'(mem_inst_resp);
            if (mem_inst_resp && (discard != '0))
                discard <= discard - 1'b1;
            if (push)
                tail <= tail + 1'b1;
            if (pop) begin
                head   <= head + 1'b1;
                out_pc <= out_pc + STEP;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !branch_valid && push)
            fifo_mem[tail] <= mem_inst_data;
    end

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Directed bench for w0rm_core_fetch with an in-order fixed-latency
// memory model; expected values are hand-derived per scenario.
module tb_w0rm_core_fetch;

    localparam logic [31:0] RST = 32'h2000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] mem_inst_addr;
    logic        mem_inst_read;
    logic        mem_inst_valid;
    logic [15:0] mem_inst_data;
    logic        mem_inst_resp;
    logic        branch_valid;
    logic [31:0] branch_addr;
    logic [15:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int passed = 0;
    int total  = 0;
    int lat    = 1;
    int reqs   = 0;
    int cyc    = 0;
    bit ovf    = 0;

    logic [31:0] q_addr [$];
    int          q_due  [$];

    w0rm_core_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .mem_inst_addr  (mem_inst_addr),
        .mem_inst_read  (mem_inst_read),
        .mem_inst_valid (mem_inst_valid),
        .mem_inst_data  (mem_inst_data),
        .mem_inst_resp  (mem_inst_resp),
        .branch_valid   (branch_valid),
        .branch_addr    (branch_addr),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] img(input logic [31:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    // Memory image: a request in cycle c is answered in cycle c+lat.
    always @(posedge clk) begin
        if (reset) begin
            q_addr.delete();
            q_due.delete();
            mem_inst_resp <= 1'b0;
        end else begin
            if (mem_inst_valid && mem_inst_read) begin
                q_addr.push_back(mem_inst_addr);
                q_due.push_back(cyc + lat);
            end
            if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
                mem_inst_resp <= 1'b1;
                mem_inst_data <= img(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                mem_inst_resp <= 1'b0;
            end
        end
        if (mem_inst_valid)
            reqs <= reqs + 1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (dut.count > 3'd4 || (dut.push && dut.count == 3'd4 && !dut.pop))
            ovf = 1'b1;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        reset = 1'b1;
        branch_valid = 1'b0;
        lat = l;
        repeat (2) go();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst_ready = 1'b0;
        branch_valid = 1'b0;
        branch_addr = '0;
        lat = 1;
        repeat (3) go();
        mid();
        total++;
        if (mem_inst_valid !== 1'b0 || mem_inst_read !== 1'b0)
            $display("FAIL reset_req: got %b%b want 00", mem_inst_valid, mem_inst_read);
        else passed++;
        total++;
        if (mem_inst_addr !== 32'h0)
            $display("FAIL reset_addr: got %h want 0", mem_inst_addr);
        else passed++;
        total++;
        if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_out !== 16'h0)
            $display("FAIL reset_out: got %b %h %h want 0 0 0", inst_valid, inst_pc, inst_out);
        else passed++;
    endtask

    task automatic test_stream();
        inst_ready = 1'b1;
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            mid();
            total++;
            if (mem_inst_valid !== 1'b1 || mem_inst_addr !== RST + 32'(2 * c))
                $display("FAIL stream_req c%0d: got %b %h want 1 %h",
                         c, mem_inst_valid, mem_inst_addr, RST + 32'(2 * c));
            else passed++;
            total++;
            if (inst_valid !== (c >= 2))
                $display("FAIL stream_valid c%0d: got %b want %b", c, inst_valid, c >= 2);
            else passed++;
            if (c >= 2) begin
                total++;
                if (inst_pc !== RST + 32'(2 * (c - 2)) || inst_out !== img(RST + 32'(2 * (c - 2))))
                    $display("FAIL stream_data c%0d: got %h %h want %h %h", c, inst_pc, inst_out,
                             RST + 32'(2 * (c - 2)), img(RST + 32'(2 * (c - 2))));
                else passed++;
            end
            go();
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        reqs = 0;
        do_reset(1);
        repeat (7) begin
            mid();
            go();
        end
        mid();
        total++;
        if (reqs !== 4)
            $display("FAIL bp_reqs: got %0d want 4", reqs);
        else passed++;
        total++;
        if (mem_inst_valid !== 1'b0 || dut.count !== 3'd4)
            $display("FAIL bp_full: got %b %0d want 0 4", mem_inst_valid, dut.count);
        else passed++;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== RST || inst_out !== img(RST))
            $display("FAIL bp_head: got %b %h %h want 1 %h %h", inst_valid, inst_pc, inst_out, RST, img(RST));
        else passed++;
        go();
        inst_ready = 1'b1;
        mid();
        total++;
        if (mem_inst_valid !== 1'b0)
            $display("FAIL bp_popcycle: got %b want 0", mem_inst_valid);
        else passed++;
        go();
        inst_ready = 1'b0;
        mid();
        total++;
        if (mem_inst_valid !== 1'b1 || mem_inst_addr !== RST + 32'd8 || inst_pc !== RST + 32'd2)
            $display("FAIL bp_resume: got %b %h %h want 1 %h %h",
                     mem_inst_valid, mem_inst_addr, inst_pc, RST + 32'd8, RST + 32'd2);
        else passed++;
        go();
        mid();
        total++;
        if (mem_inst_valid !== 1'b0 || reqs !== 5)
            $display("FAIL bp_one: got %b %0d want 0 5", mem_inst_valid, reqs);
        else passed++;
        go();
    endtask

    task automatic test_branch_stale();
        inst_ready = 1'b1;
        do_reset(3);
        repeat (3) go();
        branch_valid = 1'b1;
        branch_addr = 32'h2000_0101;
        mid();
        total++;
        if (mem_inst_valid !== 1'b0)
            $display("FAIL stale_noissue: got %b want 0", mem_inst_valid);
        else passed++;
        go();
        branch_valid = 1'b0;
        mid();
        total++;
        if (mem_inst_valid !== 1'b1 || mem_inst_addr !== 32'h2000_0100)
            $display("FAIL stale_target: got %b %h want 1 20000100", mem_inst_valid, mem_inst_addr);
        else passed++;
        total++;
        if (dut.discard !== 3'd2 || inst_valid !== 1'b0)
            $display("FAIL stale_discard: got %0d %b want 2 0", dut.discard, inst_valid);
        else passed++;
        for (int c = 5; c < 8; c++) begin
            go();
            mid();
            total++;
            if (inst_valid !== 1'b0)
                $display("FAIL stale_drop c%0d: got %b want 0", c, inst_valid);
            else passed++;
        end
        go();
        mid();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h2000_0100 || inst_out !== img(32'h2000_0100))
            $display("FAIL stale_first: got %b %h %h want 1 20000100 %h",
                     inst_valid, inst_pc, inst_out, img(32'h2000_0100));
        else passed++;
        go();
    endtask

    task automatic test_branch_pop();
        inst_ready = 1'b1;
        do_reset(2);
        repeat (3) go();
        branch_valid = 1'b1;
        branch_addr = 32'h0000_0300;
        mid();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== RST || mem_inst_valid !== 1'b0)
            $display("FAIL bpop_pre: got %b %h %b want 1 %h 0", inst_valid, inst_pc, mem_inst_valid, RST);
        else passed++;
        go();
        branch_valid = 1'b0;
        mid();
        total++;
        if (dut.count !== 3'd0 || dut.discard !== 3'd1 || inst_valid !== 1'b0)
            $display("FAIL bpop_state: got %0d %0d %b want 0 1 0", dut.count, dut.discard, inst_valid);
        else passed++;
        total++;
        if (mem_inst_valid !== 1'b1 || mem_inst_addr !== 32'h300)
            $display("FAIL bpop_req: got %b %h want 1 300", mem_inst_valid, mem_inst_addr);
        else passed++;
        for (int c = 5; c < 7; c++) begin
            go();
            mid();
            total++;
            if (inst_valid !== 1'b0)
                $display("FAIL bpop_drop c%0d: got %b want 0", c, inst_valid);
            else passed++;
        end
        go();
        mid();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst_out !== img(32'h300))
            $display("FAIL bpop_first: got %b %h %h want 1 300 %h", inst_valid, inst_pc, inst_out, img(32'h300));
        else passed++;
        go();
    endtask

    task automatic test_double_branch();
        inst_ready = 1'b1;
        do_reset(2);
        repeat (3) go();
        branch_valid = 1'b1;
        branch_addr = 32'h100;
        go();
        branch_valid = 1'b0;
        mid();
        total++;
        if (mem_inst_addr !== 32'h100 || inst_valid !== 1'b0)
            $display("FAIL dbl_first: got %h %b want 100 0", mem_inst_addr, inst_valid);
        else passed++;
        go();
        branch_valid = 1'b1;
        branch_addr = 32'h200;
        go();
        branch_valid = 1'b0;
        mid();
        total++;
        if (mem_inst_addr !== 32'h200 || dut.discard !== 3'd1)
            $display("FAIL dbl_second: got %h %0d want 200 1", mem_inst_addr, dut.discard);
        else passed++;
        for (int c = 6; c < 14; c++) begin
            if (c > 6) begin
                go();
                mid();
            end
            total++;
            if (inst_valid !== (c >= 9))
                $display("FAIL dbl_valid c%0d: got %b want %b", c, inst_valid, c >= 9);
            else passed++;
            if (c >= 9) begin
                total++;
                if (inst_pc !== 32'(32'h200 + 2 * (c - 9)) || inst_out !== img(32'(32'h200 + 2 * (c - 9))))
                    $display("FAIL dbl_data c%0d: got %h %h want %h", c, inst_pc, inst_out,
                             32'(32'h200 + 2 * (c - 9)));
                else passed++;
            end
        end
        go();
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b1;
        do_reset(1);
        repeat (5) go();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid();
            total++;
            if (inst_valid !== 1'b0 || mem_inst_valid !== 1'b0 || inst_pc !== 32'h0 ||
                mem_inst_addr !== 32'h0 || inst_out !== 16'h0 || mem_inst_read !== 1'b0)
                $display("FAIL rmid_zero k%0d: got %b %b %h %h %h want all 0",
                         k, inst_valid, mem_inst_valid, inst_pc, mem_inst_addr, inst_out);
            else passed++;
            go();
        end
        reset = 1'b0;
        mid();
        total++;
        if (mem_inst_valid !== 1'b1 || mem_inst_addr !== RST || inst_pc !== RST || inst_valid !== 1'b0)
            $display("FAIL rmid_restart: got %b %h %h %b want 1 %h %h 0",
                     mem_inst_valid, mem_inst_addr, inst_pc, inst_valid, RST, RST);
        else passed++;
        go();
        mid();
        total++;
        if (inst_valid !== 1'b0)
            $display("FAIL rmid_nostale: got %b want 0", inst_valid);
        else passed++;
        go();
        mid();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== RST || inst_out !== img(RST))
            $display("FAIL rmid_first: got %b %h %h want 1 %h %h", inst_valid, inst_pc, inst_out, RST, img(RST));
        else passed++;
        go();
    endtask

    task automatic test_wrap();
        inst_ready = 1'b1;
        do_reset(1);
        repeat (2) go();
        branch_valid = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        go();
        branch_valid = 1'b0;
        go();
        mid();
        total++;
        if (mem_inst_addr !== 32'hFFFF_FFFE)
            $display("FAIL wrap_req1: got %h want fffffffe", mem_inst_addr);
        else passed++;
        go();
        mid();
        total++;
        if (mem_inst_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req2: got %h %h want 0 fffffffc", mem_inst_addr, inst_pc);
        else passed++;
        go();
        go();
        mid();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== img(32'h0))
            $display("FAIL wrap_pc: got %b %h %h want 1 0 %h", inst_valid, inst_pc, inst_out, img(32'h0));
        else passed++;
        go();
    endtask

    initial begin
        reset = 1'b1;
        mem_inst_resp = 1'b0;
        mem_inst_data = '0;
        branch_valid = 1'b0;
        branch_addr = '0;
        inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_stale();
        test_branch_pop();
        test_double_branch();
        test_reset_mid();
        test_wrap();
        total++;
        if (ovf !== 1'b0)
            $display("FAIL no_overflow: got %b want 0", ovf);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
